// File: rtl/noise_voice.sv
// rtl/noise_voice.sv - LFSR noise voice with pitch divider and decaying envelope (option: NOISE_RESEED_EN)
module noise_voice #(
    parameter int LFSR_W   = 15,
    parameter int PERIOD_W = 8,
    parameter int VOL_W    = 4,
    parameter int OUT_W    = 13
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sample_clk,
    input  logic                tick_clk,
    input  logic                song_clk,
    input  logic                note_trigger,
    input  logic [PERIOD_W-1:0] period,
    input  logic                short_mode,
    input  logic [VOL_W-1:0]    start_atten,
    input  logic [2:0]          decay_rate,
    output logic [OUT_W-1:0]    audio_out
);

    typedef enum logic {MUTE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [VOL_W-1:0] ATTEN_MAX = '1;

    logic [LFSR_W-1:0]   lfsr;
    logic [PERIOD_W-1:0] div_cnt;
    logic [VOL_W-1:0]    atten, atten_d;
    logic [2:0]          env_cnt, env_cnt_d, env_inc;
    state_t              state, state_d;
    logic                trigger, fb, step_en;
    logic [7:0]          shifted;

    assign trigger = note_trigger & tick_clk & song_clk;
    assign fb      = lfsr[0] ^ (short_mode ? lfsr[6] : lfsr[1]);
    // A trigger restarts the divider and suppresses a coincident step.
    assign step_en = sample_clk & ~trigger & (div_cnt == period);
    assign env_inc = env_cnt + 3'd1;
    assign shifted = lfsr[7:0] >> atten[VOL_W-1:1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr    <= '1;
            div_cnt <= '0;
        end else begin
            if (trigger)
                div_cnt <= '0;
            else if (sample_clk)
                div_cnt <= (div_cnt == period) ? '0 : div_cnt + PERIOD_W'(1);
`ifdef NOISE_RESEED_EN
            if (trigger)
                lfsr <= '1;
            else if (step_en)
                lfsr <= {fb, lfsr[LFSR_W-1:1]};
`else
            if (step_en)
                lfsr <= {fb, lfsr[LFSR_W-1:1]};
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= MUTE;
            atten   <= ATTEN_MAX;
            env_cnt <= '0;
        end else begin
            state   <= state_d;
            atten   <= atten_d;
            env_cnt <= env_cnt_d;
        end
    end

    always_comb begin
        state_d   = state;
        atten_d   = atten;
        env_cnt_d = env_cnt;
        if (trigger) begin
            atten_d   = start_atten;
            env_cnt_d = '0;
            state_d   = (start_atten == ATTEN_MAX) ? MUTE : ACTIVE;
        end else if (state == ACTIVE) begin
            if (decay_rate == 3'd0) begin
                env_cnt_d = '0;
            end else if (tick_clk) begin
                if (env_inc == decay_rate) begin
                    env_cnt_d = '0;
                    atten_d   = atten + VOL_W'(1);
                    if (atten_d == ATTEN_MAX)
                        state_d = MUTE;
                end else begin
                    env_cnt_d = env_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            audio_out <= '0;
        else
            audio_out <= (atten == ATTEN_MAX) ? '0 : {{(OUT_W-8){1'b0}}, shifted};
    end

endmodule

// File: tb/tb_noise_voice.sv
// tb/tb_noise_voice.sv - directed self-checking bench for noise_voice
module tb_noise_voice;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sample_clk, tick_clk, song_clk, note_trigger, short_mode;
    logic [7:0]  period;
    logic [3:0]  start_atten;
    logic [2:0]  decay_rate;
    logic [12:0] audio_out;

    int errors = 0;
    int checks = 0;
    int n;
    logic [14:0] m;
    logic [14:0] seq_a [16];
    logic [14:0] seq_b [16];
    logic same, exp_same;

    noise_voice dut (
        .clk(clk), .rst_n(rst_n), .sample_clk(sample_clk), .tick_clk(tick_clk),
        .song_clk(song_clk), .note_trigger(note_trigger), .period(period),
        .short_mode(short_mode), .start_atten(start_atten), .decay_rate(decay_rate),
        .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [14:0] lfsr_step(input logic [14:0] l, input logic s);
        lfsr_step = {l[0] ^ (s ? l[6] : l[1]), l[14:1]};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Strobes and a trigger asserted during reset must be ignored
        rst_n = 1'b0; sample_clk = 1'b1; tick_clk = 1'b1; song_clk = 1'b1; note_trigger = 1'b1;
        period = 8'd0; short_mode = 1'b0; start_atten = 4'd0; decay_rate = 3'd2;
        repeat (3) cyc();
        chk("rst_audio", 32'(audio_out), 32'h0);
        chk("rst_lfsr", 32'(dut.lfsr), 32'h7FFF);
        chk("rst_atten", 32'(dut.atten), 32'hF);
        chk("rst_div", 32'(dut.div_cnt), 32'h0);
        chk("rst_env", 32'(dut.env_cnt), 32'h0);
        chk("rst_state", 32'(logic'(dut.state)), 32'h0);

        sample_clk = 1'b0; tick_clk = 1'b0; song_clk = 1'b0; note_trigger = 1'b0;
        period = 8'hFF; rst_n = 1'b1;
        cyc();
        sample_clk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            chk("mute_audio", 32'(audio_out), 32'h0);
        end
        sample_clk = 1'b0;
        chk("div_count100", 32'(dut.div_cnt), 32'd100);
        chk("no_step_lfsr", 32'(dut.lfsr), 32'h7FFF);

        // Asynchronous reset takes effect without a clock edge
        #2 rst_n = 1'b0;
        #1 chk("async_rst_div", 32'(dut.div_cnt), 32'h0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Long mode, one step per strobe
        period = 8'd0; short_mode = 1'b0; sample_clk = 1'b1;
        cyc();
        chk("long_step1", 32'(dut.lfsr), 32'h3FFF);
        repeat (4) cyc();
        chk("long_step5", 32'(dut.lfsr), 32'h03FF);
        n = 5;
        while (n < 40000 && dut.lfsr !== 15'h7FFF) begin
            cyc();
            n++;
        end
        sample_clk = 1'b0;
        chk("long_period", 32'(n), 32'd32767);

        // Divider period 3: one step per four strobes
        period = 8'd3; sample_clk = 1'b1;
        repeat (3) cyc();
        chk("div3_hold", 32'(dut.lfsr), 32'h7FFF);
        chk("div3_cnt", 32'(dut.div_cnt), 32'd3);
        cyc();
        chk("div3_step", 32'(dut.lfsr), 32'h3FFF);
        chk("div3_wrap", 32'(dut.div_cnt), 32'd0);
        repeat (4) cyc();
        chk("div3_step2", 32'(dut.lfsr), 32'h1FFF);
        sample_clk = 1'b0;

        // Short mode: tap at bit 6 first diverges from long mode at step 10
        do_reset();
        period = 8'd0; short_mode = 1'b1; sample_clk = 1'b1;
        repeat (10) cyc();
        chk("short_step10", 32'(dut.lfsr), 32'h401F);
        m = 15'h401F;
        for (int i = 0; i < 100; i++) begin
            cyc();
            m = lfsr_step(m, 1'b1);
            chk("short_seq", 32'(dut.lfsr), 32'(m));
        end
        sample_clk = 1'b0; short_mode = 1'b0;

        // Envelope decay with LFSR frozen at all ones
        do_reset();
        period = 8'hFF; song_clk = 1'b1;
        tick_clk = 1'b1; note_trigger = 1'b1; start_atten = 4'd0; decay_rate = 3'd2;
        cyc();
        note_trigger = 1'b0; tick_clk = 1'b0;
        chk("trig_atten", 32'(dut.atten), 32'h0);
        chk("trig_state", 32'(logic'(dut.state)), 32'h1);
        cyc();
        chk("trig_audio", 32'(audio_out), 32'hFF);
        tick_clk = 1'b1;
        cyc();
        chk("tick1_env", 32'(dut.env_cnt), 32'h1);
        chk("tick1_atten", 32'(dut.atten), 32'h0);
        cyc();
        chk("tick2_atten", 32'(dut.atten), 32'h1);
        repeat (2) cyc();
        chk("tick4_atten", 32'(dut.atten), 32'h2);
        repeat (4) cyc();
        tick_clk = 1'b0;
        chk("tick8_atten", 32'(dut.atten), 32'h4);
        cyc();
        chk("atten4_audio", 32'(audio_out), 32'h3F);
        tick_clk = 1'b1;
        repeat (21) cyc();
        chk("tick29_atten", 32'(dut.atten), 32'hE);
        chk("tick29_state", 32'(logic'(dut.state)), 32'h1);
        cyc();
        chk("tick30_atten", 32'(dut.atten), 32'hF);
        chk("tick30_state", 32'(logic'(dut.state)), 32'h0);
        repeat (4) cyc();
        chk("mute_hold", 32'(dut.atten), 32'hF);
        chk("mute_audio2", 32'(audio_out), 32'h0);

        // Trigger at full attenuation leaves the voice muted
        note_trigger = 1'b1; start_atten = 4'hF;
        cyc();
        chk("trigmax_state", 32'(logic'(dut.state)), 32'h0);

        // Retrigger while active; trigger beats the pending decay step
        start_atten = 4'd0;
        cyc();
        note_trigger = 1'b0;
        repeat (19) cyc();
        chk("pre_retrig_atten", 32'(dut.atten), 32'h9);
        chk("pre_retrig_env", 32'(dut.env_cnt), 32'h1);
        note_trigger = 1'b1; start_atten = 4'd3;
        cyc();
        note_trigger = 1'b0; tick_clk = 1'b0;
        chk("retrig_atten", 32'(dut.atten), 32'h3);
        chk("retrig_env", 32'(dut.env_cnt), 32'h0);

        // Trigger coincident with a sample strobe
        period = 8'd5; sample_clk = 1'b1;
        repeat (2) cyc();
        chk("pre_coinc_div", 32'(dut.div_cnt), 32'h2);
        tick_clk = 1'b1; note_trigger = 1'b1;
        cyc();
        tick_clk = 1'b0; note_trigger = 1'b0; sample_clk = 1'b0;
        chk("coinc_div", 32'(dut.div_cnt), 32'h0);
        chk("coinc_lfsr", 32'(dut.lfsr), 32'h7FFF);

        // decay_rate 0 holds the level
        decay_rate = 3'd0; tick_clk = 1'b1;
        repeat (5) cyc();
        tick_clk = 1'b0;
        chk("hold_atten", 32'(dut.atten), 32'h3);
        chk("hold_env", 32'(dut.env_cnt), 32'h0);

        // Noise sequence after two successive triggers
        period = 8'd0;
        tick_clk = 1'b1; note_trigger = 1'b1;
        cyc();
        tick_clk = 1'b0; note_trigger = 1'b0; sample_clk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            seq_a[i] = dut.lfsr;
        end
        sample_clk = 1'b0;
        tick_clk = 1'b1; note_trigger = 1'b1;
        cyc();
        tick_clk = 1'b0; note_trigger = 1'b0; sample_clk = 1'b1;
        for (int i = 0; i < 16; i++) begin
            cyc();
            seq_b[i] = dut.lfsr;
        end
        sample_clk = 1'b0;
        same = 1'b1;
        for (int i = 0; i < 16; i++)
            if (seq_a[i] !== seq_b[i]) same = 1'b0;
`ifdef NOISE_RESEED_EN
        exp_same = 1'b1;
`else
        exp_same = 1'b0;
`endif
        chk("seq_a_first", 32'(seq_a[0]), 32'h3FFF);
        chk("reseed_match", 32'(same), 32'(exp_same));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
